// File: rtl/prange_pkg.sv
// prange_pkg: state encoding and range arithmetic shared by the prange generator.
// Helpers work on PRANGE_MAXW-bit sign-extended operands; callers pass their real width.
package prange_pkg;

    localparam int PRANGE_MAXW = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } prange_state_t;

    function automatic logic prange_cont(
        input logic signed [PRANGE_MAXW-1:0] i,
        input logic signed [PRANGE_MAXW-1:0] limit,
        input logic signed [PRANGE_MAXW-1:0] step
    );
        logic neg;
        logic pos;
        neg = step[PRANGE_MAXW-1];
        pos = !neg && (step != '0);
        return (pos && (i < limit)) || (neg && (i > limit));
    endfunction

    // The exact sum of two w-bit values fits in w+1 bits, so overflow shows as bit w != bit w-1.
    function automatic logic signed [PRANGE_MAXW-1:0] prange_next(
        input  logic signed [PRANGE_MAXW-1:0] i,
        input  logic signed [PRANGE_MAXW-1:0] step,
        input  logic [6:0]                    w,
        output logic                          ovf
    );
        logic signed [PRANGE_MAXW:0] sum;
        sum = (PRANGE_MAXW+1)'(i) + (PRANGE_MAXW+1)'(step);
        ovf = sum[w] ^ sum[w - 7'd1];
        return sum[PRANGE_MAXW-1:0];
    endfunction

endpackage

// File: rtl/prange_skid.sv
// prange_skid: 2-entry ready/valid buffer between the range generator and its consumer.
// Latency: a push is visible on pop_* after the next edge; flush empties it on that edge.
// Backpressure: can_push/drained report the occupancy after the coming edge, so the producer never overruns.
module prange_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    output logic          can_push,
    output logic          drained,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [DW-1:0] pop_dat
);

    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] e0_q, e0_d;
    logic [DW-1:0] e1_q, e1_d;
    logic          pop;
    logic [1:0]    lvl;

    assign pop_vld  = (cnt_q != 2'd0);
    assign pop_dat  = e0_q;
    assign pop      = pop_vld && pop_rdy;
    assign lvl      = cnt_q + {1'b0, push_vld} - {1'b0, pop};
    assign can_push = (lvl <= 2'd1);
    assign drained  = (lvl == 2'd0);

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_vld, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = push_dat;
                    else               e1_d = push_dat;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = push_dat;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

// File: rtl/prange.sv
// prange: range(base, limit, step) item generator; defining PRANGE_INDEX_EN adds the _out_1 item index.
// Latency: first item valid on the second edge after the _start edge, then one item per cycle.
// Backpressure: generator stalls whenever the 2-entry skid could overfill; no combinational _ready-to-output path.
module prange
    import prange_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 16
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
`ifdef PRANGE_INDEX_EN
    output logic [IDX_WIDTH-1:0]    _out_1,
`endif
    output logic signed [WIDTH-1:0] _out_0
);

`ifdef PRANGE_INDEX_EN
    localparam bit INDEX_EN = 1'b1;
`else
    localparam bit INDEX_EN = 1'b0;
`endif
    localparam int DW = WIDTH + (INDEX_EN ? IDX_WIDTH : 0);

    prange_state_t           state_q, state_d;
    logic signed [WIDTH-1:0] i_q, i_d;
    logic signed [WIDTH-1:0] limit_q, limit_d;
    logic signed [WIDTH-1:0] step_q, step_d;
    logic                    push_q, push_d;
    logic [DW-1:0]           push_dat_q, push_dat_d;
    logic                    done_q, done_d;
`ifdef PRANGE_INDEX_EN
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
`endif

    logic                    can_push;
    logic                    drained;
    logic [DW-1:0]           pop_dat;
    logic                    cont;
    logic                    ovf;
    logic signed [WIDTH-1:0] i_nxt;

    always_comb begin
        ovf   = 1'b0;
        cont  = prange_cont(PRANGE_MAXW'(i_q), PRANGE_MAXW'(limit_q), PRANGE_MAXW'(step_q));
        i_nxt = WIDTH'(prange_next(PRANGE_MAXW'(i_q), PRANGE_MAXW'(step_q), 7'(WIDTH), ovf));
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        limit_d    = limit_q;
        step_d     = step_q;
        push_d     = 1'b0;
        push_dat_d = push_dat_q;
        done_d     = done_q;
`ifdef PRANGE_INDEX_EN
        idx_d      = idx_q;
`endif
        if (_start) begin
            state_d = RUN;
            i_d     = base;
            limit_d = limit;
            step_d  = step;
            done_d  = 1'b0;
`ifdef PRANGE_INDEX_EN
            idx_d   = '0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (can_push) begin
                        if (cont) begin
                            push_d = 1'b1;
`ifdef PRANGE_INDEX_EN
                            push_dat_d = {idx_q, i_q};
                            idx_d      = idx_q + IDX_WIDTH'(1);
`else
                            push_dat_d = i_q;
`endif
                            i_d = i_nxt;
                            // A wrapped successor is never emitted: stop right after this item.
                            if (ovf) state_d = DRAIN;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            limit_q    <= '0;
            step_q     <= '0;
            push_q     <= 1'b0;
            push_dat_q <= '0;
            done_q     <= 1'b1;
`ifdef PRANGE_INDEX_EN
            idx_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            limit_q    <= limit_d;
            step_q     <= step_d;
            push_q     <= push_d;
            push_dat_q <= push_dat_d;
            done_q     <= done_d;
`ifdef PRANGE_INDEX_EN
            idx_q      <= idx_d;
`endif
        end
    end

    prange_skid #(
        .DW (DW)
    ) u_skid (
        .clk      (_clock),
        .rst      (_reset),
        .flush    (_start),
        .push_vld (push_q),
        .push_dat (push_dat_q),
        .can_push (can_push),
        .drained  (drained),
        .pop_vld  (_valid),
        .pop_rdy  (_ready),
        .pop_dat  (pop_dat)
    );

    assign _done  = done_q;
    assign _out_0 = pop_dat[WIDTH-1:0];
`ifdef PRANGE_INDEX_EN
    assign _out_1 = pop_dat[DW-1:WIDTH];
`endif

endmodule

// File: tb/tb_prange.sv
// tb_prange: vector table, randomized ranges and hand-written restart/reset/overflow sequences for prange.
module tb_prange;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, ready, vld, done;
    logic signed [31:0] base_i, limit_i, step_i, out0;
    logic [15:0]        out1;

    logic               start8, rdy8, vld8, done8;
    logic signed [7:0]  base8, lim8, step8, out8;
    logic [15:0]        out1_8;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        longint b;
        longint l;
        longint s;
        int     rmode;
        int     n;
    } vec_t;

    vec_t   tbl [10];
    logic   pat [0:6];
    int     got_h;
    logic   d8;
    longint q8[$];

    always #5 clk = ~clk;

    prange u_dut (
        ._clock (clk),
        ._reset (rst),
        ._start (start),
        .base   (base_i),
        .limit  (limit_i),
        .step   (step_i),
        ._ready (ready),
        ._valid (vld),
        ._done  (done),
`ifdef PRANGE_INDEX_EN
        ._out_1 (out1),
`endif
        ._out_0 (out0)
    );

    prange #(.WIDTH(8), .IDX_WIDTH(16)) u_dut8 (
        ._clock (clk),
        ._reset (rst),
        ._start (start8),
        .base   (base8),
        .limit  (lim8),
        .step   (step8),
        ._ready (rdy8),
        ._valid (vld8),
        ._done  (done8),
`ifdef PRANGE_INDEX_EN
        ._out_1 (out1_8),
`endif
        ._out_0 (out8)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Python range() with a w-bit signed value domain: stop once the next value leaves the domain.
    function automatic void model(input longint b, input longint l, input longint s,
                                  input int w, output longint q[$]);
        longint v, lo, hi;
        lo = -(longint'(1) <<< (w - 1));
        hi = (longint'(1) <<< (w - 1)) - 1;
        q.delete();
        v = b;
        while (((s > 0 && v < l) || (s < 0 && v > l)) && q.size() < 1000) begin
            q.push_back(v);
            v = v + s;
            if (v < lo || v > hi) break;
        end
    endfunction

    function automatic logic pick_ready(input int rmode, input int k);
        if (rmode == 1) return ($urandom_range(0, 3) != 0);
        if (rmode == 2) return (k >= 2 && k - 2 < 7) ? pat[k-2] : 1'b1;
        return 1'b1;
    endfunction

    task automatic run_stream(input longint b, input longint l, input longint s,
                              input int rmode, input int exp_n);
        longint q[$];
        longint prev_val;
        int     nmod, got, first_k, done_k, last_k;
        logic   r, prev_stall, prev_xfer;
        model(b, l, s, 32, q);
        nmod    = q.size();
        base_i  = 32'(b);
        limit_i = 32'(l);
        step_i  = 32'(s);
        ready   = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_vld", vld, 0);
        chk("start_done", done, 0);
        got = 0; first_k = -1; done_k = -1; last_k = -1;
        prev_stall = 1'b0; prev_xfer = 1'b0; prev_val = 0;
        ready = pick_ready(rmode, 0);
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            chk("vld_done_excl", longint'(vld & done), 0);
            if (prev_stall) begin
                chk("stall_vld", vld, 1);
                chk("stall_val", out0, prev_val);
            end
            if (prev_xfer && q.size() > 0) chk("no_gap", vld, 1);
            if (done) begin
                done_k = k;
                break;
            end
            if (vld) begin
                if (first_k < 0) first_k = k;
                if (q.size() > 0) chk("item_val", out0, q[0]);
                else              chk("extra_item", vld, 0);
`ifdef PRANGE_INDEX_EN
                chk("item_idx", out1, got);
`endif
            end
            r = pick_ready(rmode, k);
            ready = r;
            prev_stall = vld && !r;
            prev_xfer  = vld && r;
            prev_val   = out0;
            if (vld && r) begin
                if (q.size() > 0) void'(q.pop_front());
                got++;
                last_k = k;
            end
        end
        chk("done_seen", longint'(done_k > 0), 1);
        chk("count_model", got, nmod);
        if (exp_n >= 0) chk("count_table", got, exp_n);
        if (nmod > 0) begin
            chk("latency", first_k, 2);
            chk("done_after_last", done_k, last_k + 1);
        end else begin
            chk("empty_done_edge", done_k, 2);
        end
        if (rmode == 0) chk("throughput", done_k, nmod + 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
        tbl[0] = '{1, 11, 3, 0, 4};
        tbl[1] = '{10, 0, -3, 0, 4};
        tbl[2] = '{5, 5, 1, 0, 0};
        tbl[3] = '{3, 9, 0, 0, 0};
        tbl[4] = '{0, 10, 2, 2, 5};
        tbl[5] = '{-5, 5, 4, 1, 3};
        tbl[6] = '{7, -8, -5, 0, 3};
        tbl[7] = '{2147483640, 2147483647, 5, 0, 2};
        tbl[8] = '{-2147483640, -64'sd2147483648, -7, 1, 2};
        tbl[9] = '{0, 1, 1, 0, 1};

        rst = 1'b1; start = 1'b0; ready = 1'b0;
        base_i = '0; limit_i = '0; step_i = '0;
        start8 = 1'b0; rdy8 = 1'b1; base8 = '0; lim8 = '0; step8 = '0;
        #12;
        chk("rst_valid", vld, 0);
        chk("rst_done", done, 1);
        chk("rst_out0", out0, 0);
        chk("rst8_done", done8, 1);
`ifdef PRANGE_INDEX_EN
        chk("rst_out1", out1, 0);
`endif
        rst = 1'b0;

        for (int t = 0; t < 10; t++)
            run_stream(tbl[t].b, tbl[t].l, tbl[t].s, tbl[t].rmode, tbl[t].n);

        for (int t = 0; t < 8; t++)
            run_stream(longint'($urandom_range(0, 80)) - 40,
                       longint'($urandom_range(0, 80)) - 40,
                       longint'($urandom_range(0, 14)) - 7, 1, -1);

        // Restart while an item is held: it is dropped and the new range starts cleanly.
        base_i = 0; limit_i = 10; step_i = 1; ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5 && !vld; k++) begin
            @(posedge clk); #1;
        end
        chk("preload_vld", vld, 1);
        run_stream(100, 103, 1, 0, 3);

        // Asynchronous reset mid-stream, then a fresh range.
        base_i = 0; limit_i = 10; step_i = 2; ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_h = 0;
        for (int k = 0; k < 20 && got_h < 4; k++) begin
            @(posedge clk); #1;
            if (vld) begin
                chk("pre_rst_item", out0, 2 * got_h);
                got_h++;
            end
        end
        @(posedge clk); #1;
        chk("pre_rst_vld", vld, 1);
        rst = 1'b1;
        #2;
        chk("mid_rst_vld", vld, 0);
        chk("mid_rst_done", done, 1);
        chk("mid_rst_out0", out0, 0);
        rst = 1'b0;
        run_stream(1, 4, 1, 0, 3);

        // 8-bit instance: 120+10 overflows, so 120 is the only item.
        model(120, 127, 10, 8, q8);
        base8 = 8'sd120; lim8 = 8'sd127; step8 = 8'sd10; rdy8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        got_h = 0; d8 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                d8 = 1'b1;
                break;
            end
            if (vld8) begin
                chk("w8_val", out8, (got_h < q8.size()) ? q8[got_h] : -999);
                got_h++;
            end
        end
        chk("w8_count", got_h, 1);
        chk("w8_done", d8, 1);
        chk("w8_vld_low", vld8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
